// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer: FSM state
// encoding, channel count/width and a lowest-set-bit helper.
package scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // First channel of a scan; an empty mask yields 0, but callers never scan then.
  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational search for the next enabled channel above the current one.
// last_o is high when no higher channel is enabled; nxt_o then holds cur_i.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              last_o
);

  always_comb begin
    nxt_o  = cur_i;
    last_o = 1'b1;
    // Descending walk so the lowest qualifying channel is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        nxt_o  = CH_W'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Channel scan sequencer: steps A through the latched mask, dwell+1 cycles per
// channel. Define SCAN_SEQ_ONEHOT_EN to add the registered one-hot output D.
module scan_seq
  import scan_pkg::state_e, scan_pkg::IDLE, scan_pkg::SCAN, scan_pkg::DONE,
         scan_pkg::CH_W, scan_pkg::lowest_ch;
#(
  parameter int DWELL_W = 4,
  parameter int NUM_CH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    A,
  output logic               valid,
  output logic               busy,
  output logic               done
`ifdef SCAN_SEQ_ONEHOT_EN
  ,
  output logic [NUM_CH-1:0]  D
`endif
);

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]    a_q, a_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CH_W-1:0]    nxt_ch;
  logic               last_ch;

  scan_next_ch u_next_ch (
    .mask_i (mask_q),
    .cur_i  (a_q),
    .nxt_o  (nxt_ch),
    .last_o (last_ch)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start && !stop) begin
          mask_d  = mask;
          dwell_d = dwell;
          cnt_d   = dwell;
          if (mask != '0) begin
            state_d = SCAN;
            a_d     = lowest_ch(mask);
            valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          // Dwell expired: hop straight to the next channel, or finish.
          if (last_ch) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            a_d   = nxt_ch;
            cnt_d = dwell_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef SCAN_SEQ_ONEHOT_EN
  // Decoded from next-state values so D lines up with A in the same cycle.
  logic [NUM_CH-1:0] d_q, d_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign d_d[gi] = valid_d && (a_d == CH_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= '0;
    else     d_q <= d_d;
  end

  assign D = d_q;
`endif

endmodule

// File: tb/tb_scan_seq.sv
// Self-checking bench for scan_seq: directed scenarios plus randomized scans
// compared cycle by cycle against an expected-trace model built from the rules.
module tb_scan_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] mask = 4'b0;
  logic [3:0] dwell = 4'b0;
  logic [1:0] A;
  logic       valid, busy, done;
`ifdef SCAN_SEQ_ONEHOT_EN
  logic [3:0] D;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] a;
    logic       v;
    logic       b;
    logic       d;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] a_hold = 2'd0;

  scan_seq #(.DWELL_W(4), .NUM_CH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mask  (mask),
    .dwell (dwell),
    .A     (A),
    .valid (valid),
    .busy  (busy),
`ifdef SCAN_SEQ_ONEHOT_EN
    .done  (done),
    .D     (D)
`else
    .done  (done)
`endif
  );

  always #5 clk = ~clk;

  // Expected per-cycle trace after a start: each enabled channel, lowest first,
  // for dwell+1 cycles; then one done cycle; then one idle cycle. A holds.
  task automatic build_expected(input logic [3:0] m, input logic [3:0] dw);
    exp_q.delete();
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k <= int'(dw); k++) exp_q.push_back('{a: 2'(ch), v: 1'b1, b: 1'b1, d: 1'b0});
        a_hold = 2'(ch);
      end
    end
    exp_q.push_back('{a: a_hold, v: 1'b0, b: 1'b1, d: 1'b1});
    exp_q.push_back('{a: a_hold, v: 1'b0, b: 1'b0, d: 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({A, valid, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hold: got A=%0d v=%0b b=%0b d=%0b, want all 0", A, valid, busy, done);
    end
    rst = 1'b0;
    a_hold = 2'd0;
    @(negedge clk);
    checks++;
    if ({A, valid, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_release: got A=%0d v=%0b b=%0b d=%0b, want all 0", A, valid, busy, done);
    end
    $display("reset: checked outputs during and after reset");
  endtask

  // One full scan checked cycle by cycle; with noise, start/mask/dwell are
  // scrambled while busy to show they are ignored.
  task automatic test_scan(input string name, input logic [3:0] m, input logic [3:0] dw, input bit noise);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    dwell = dw;
    build_expected(m, dw);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      e = exp_q[i];
      checks++;
      if ({A, valid, busy, done} !== e) begin
        failures++;
        $display("FAIL %s cyc%0d: got A=%0d v=%0b b=%0b d=%0b, want A=%0d v=%0b b=%0b d=%0b",
                 name, i, A, valid, busy, done, e.a, e.v, e.b, e.d);
      end
`ifdef SCAN_SEQ_ONEHOT_EN
      checks++;
      if (D !== (e.v ? (4'b0001 << e.a) : 4'b0000)) begin
        failures++;
        $display("FAIL %s_onehot cyc%0d: got D=%b, want D=%b", name, i, D,
                 e.v ? (4'b0001 << e.a) : 4'b0000);
      end
`endif
      if (noise) begin
        mask  = 4'($urandom);
        dwell = 4'($urandom);
        start = (i < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("scan %s: mask=%b dwell=%0d cycles=%0d", name, m, dw, exp_q.size());
  endtask

  task automatic test_stop();
    @(negedge clk);
    start = 1'b1; mask = 4'b1111; dwell = 4'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({A, valid, busy} !== {(c <= 4) ? 2'd0 : 2'd1, 2'b11}) begin
        failures++;
        $display("FAIL stop_prescan cyc%0d: got A=%0d v=%0b b=%0b", c, A, valid, busy);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    a_hold = 2'd1;
    checks++;
    if ({A, valid, busy, done} !== {2'd1, 3'b000}) begin
      failures++;
      $display("FAIL stop_scan: got A=%0d v=%0b b=%0b d=%0b, want A=1 v=0 b=0 d=0", A, valid, busy, done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({done, busy, valid} !== 3'b000) begin
        failures++;
        $display("FAIL stop_quiet cyc%0d: got d=%0b b=%0b v=%0b, want 0", c, done, busy, valid);
      end
    end
    // Stop while in DONE.
    start = 1'b1; mask = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b11) begin
      failures++;
      $display("FAIL stop_done_pre: got d=%0b b=%0b, want d=1 b=1", done, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({A, valid, busy, done} !== {a_hold, 3'b000}) begin
      failures++;
      $display("FAIL stop_done: got A=%0d v=%0b b=%0b d=%0b, want A=%0d rest 0", A, valid, busy, done, a_hold);
    end
    // Start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; mask = 4'b1111;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL start_stop_same: got v=%0b b=%0b d=%0b, want 0", valid, busy, done);
    end
    $display("stop: abort in SCAN, in DONE and stop-over-start");
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; mask = 4'b1111; dwell = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({A, valid, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL rst_async: got A=%0d v=%0b b=%0b d=%0b, want all 0", A, valid, busy, done);
    end
`ifdef SCAN_SEQ_ONEHOT_EN
    checks++;
    if (D !== 4'b0) begin
      failures++;
      $display("FAIL rst_async_onehot: got D=%b, want 0000", D);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    a_hold = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({A, valid, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL rst_no_done: got A=%0d v=%0b b=%0b d=%0b, want all 0", A, valid, busy, done);
    end
    $display("reset mid-scan: outputs cleared, no done pulse");
    test_scan("after_rst", 4'b0100, 4'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      test_scan("random", 4'($urandom), 4'($urandom), 1'b1);
  endtask

  initial begin
    test_reset();
    test_scan("full_d0", 4'b1111, 4'd0, 1'b0);
    test_scan("sparse_d2", 4'b1010, 4'd2, 1'b0);
    test_scan("empty", 4'b0000, 4'd5, 1'b0);
    test_stop();
    test_rst_mid();
    test_scan("dwell_max", 4'b1001, 4'hF, 1'b1);
    test_scan("back_to_back", 4'b0110, 4'd1, 1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
